shift_add_mult8: RTL and testbench
==================================

# shift_add_mult8

Sequential 8x8 unsigned multiplier built on the team's 8-bit ripple-carry adder. It accepts two operands on a start strobe and runs one shift-and-add step per clock. It presents the 16-bit product with a one-cycle done pulse. It sits directly upstream of the adder stage and consumes its sum and carry-out every cycle. Lab datapath use: operand switches/registers in, product to display logic out.

## Interface
- `WIDTH`, 8: operand width. Only 8 is supported, because it is fixed by the adder sub-module. It is exposed for documentation only.
- `clk`  in  1  sole clock; all state updates on rising edge
- `rst_n`  in  1  synchronous reset, active-low
- `start`  in  1  request; sampled only in IDLE
- `a`  in  8  multiplicand; captured on accepted start
- `b`  in  8  multiplier; captured on accepted start
- `busy`  out  1  high in RUN and DONE
- `done`  out  1  one-cycle pulse; `p` is valid from this cycle onward
- `p`  out  16  product register; holds its value until the next completion

## Operation
- Internal registers:
  - `mcand[7:0]`
  - `acc[15:0]`: upper half is the partial sum, lower half holds the multiplier bits still to be consumed.
  - `cnt[2:0]`
  - `state`
- FSM states: IDLE, RUN, DONE.
- **IDLE**
  - If `start`=1: `mcand`<=`a`, `acc`<={8'h00, `b`}, `cnt`<=0, state<=RUN.
  - Otherwise hold.
- **RUN**, each cycle:
  - addend = `acc[0]` ? `mcand` : 8'h00.
  - Adder computes {c, s} = `acc[15:8]` + addend, with cin tied 0.
  - `acc` <= {c, s, `acc[7:1]`}. This is a 17-bit result truncated by the shift, so no bit is lost.
  - `cnt` <= `cnt`+1.
  - When `cnt`==7: `p` <= next `acc` value, state<=DONE.
- **DONE**: `done`=1 for this cycle only; state<=IDLE next edge.
- `start` in RUN or DONE is ignored, with no queueing. Operand changes after capture have no effect.
- Arithmetic is unsigned. The full product is 0..65025 (0xFE01), so no overflow is possible in 16 bits.
- Reset values (`rst_n`=0 at an edge): state=IDLE, `busy`=0, `done`=0, `p`=16'h0000, `acc`=0, `mcand`=0, `cnt`=0.
- Reset mid-RUN or in DONE aborts the operation: no `done` pulse is issued and `p` is cleared to 0.
- Reset has priority over `start` on the same edge.

## Timing
- `start` is sampled at edge k (state IDLE).
- `busy`=1 from after edge k through the DONE cycle.
- RUN steps occur at edges k+1 .. k+8.
- `p` is updated at edge k+8. DONE is the cycle after edge k+8, and `done`=1 in that cycle.
- Edge k+9 returns to IDLE. The earliest next accepted `start` is at edge k+10.
- Latency is 9 cycles from start sample to done; throughput is 1 product per 10 cycles.
- `busy` and `done` are registered or decoded from the state register only, never from inputs. This keeps them glitch-free for the downstream logic.
- The adder path (8-stage ripple) is the critical path and must close within one `clk` period.

## Structure
- Shared package: state encoding constants `ST_IDLE`=2'd0, `ST_RUN`=2'd1, `ST_DONE`=2'd2, and the step count constant `STEPS`=8.
- One sub-module: instantiate `RippleCarry` with ports (a, b, cin, cout, s) as the add step. Do not re-implement the adder inline.
- The FSM, counter and shift register live in `shift_add_mult8` itself.

## Test plan
- a=5, b=3 with a start pulse: `done` occurs exactly 9 cycles after the start edge, `p`=16'd15, and `busy` is high for 9 cycles.
- a=255, b=255: `p`=16'hFE01. This checks the carry-out shift on every step.
- a=0x00, b=0xAB, then a=0x80, b=0x02 back-to-back (second start at the earliest legal edge): `p`=0x0000, then `p`=0x0100, with two `done` pulses 10 cycles apart.
- Hold `start`=1 continuously and change `a`/`b` during RUN: only the operands captured at acceptance are used, and each product is correct for its captured pair.
- Assert `rst_n`=0 at the 4th RUN edge of a=7, b=9: the next cycle shows state IDLE, `busy`=0, `p`=0, and no `done`. A following start with a=7, b=9 yields `p`=63.

Source files
------------

// File: rtl/shift_add_mult8_pkg.sv
// Shared constants and state encoding for the sequential shift-and-add multiplier.
//   ST_IDLE/ST_RUN/ST_DONE : FSM state encoding
//   STEPS                  : shift-and-add steps per product (one per multiplier bit)
//   ADD_W                  : width of the ripple-carry adder stage
package shift_add_mult8_pkg;

  localparam int unsigned ADD_W = 8;
  localparam int unsigned STEPS = 8;
  localparam int unsigned CNT_W = 3;
  localparam int unsigned PROD_W = 2 * ADD_W;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/shift_add_mult8_ripple.sv
// 8-bit ripple-carry adder used as the multiplier's add step.
//   a, b : addends
//   cin  : carry in
//   cout : carry out of the top bit
//   s    : sum
module RippleCarry
  import shift_add_mult8_pkg::*;
(
  input  logic [ADD_W-1:0] a,
  input  logic [ADD_W-1:0] b,
  input  logic             cin,
  output logic             cout,
  output logic [ADD_W-1:0] s
);

  logic [ADD_W:0] c;

  assign c[0] = cin;

  // One full adder per bit; carry ripples upward.
  for (genvar i = 0; i < int'(ADD_W); i++) begin : g_fa
    assign s[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end

  assign cout = c[ADD_W];

endmodule

// File: rtl/shift_add_mult8.sv
// Sequential 8x8 unsigned multiplier: one shift-and-add step per clock.
//   clk   : clock, rising edge
//   rst_n : synchronous reset, active-low
//   start : request, honoured only while idle
//   a, b  : multiplicand / multiplier, captured on an accepted start
//   busy  : high from acceptance through the done cycle
//   done  : one-cycle pulse; p valid from this cycle on
//   p     : product, held until the next completion
module shift_add_mult8
  import shift_add_mult8_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   p
);

  state_t              state;
  state_t              state_next;
  logic                busy_next;
  logic                done_next;
  logic                step_last;

  logic [ADD_W-1:0]    mcand;
  logic [PROD_W-1:0]   acc;
  logic [CNT_W-1:0]    cnt;

  logic [ADD_W-1:0]    addend;
  logic [ADD_W-1:0]    sum;
  logic                carry;
  logic [PROD_W-1:0]   acc_step;

  // Add the multiplicand into the upper half when the current multiplier bit is set.
  assign addend = acc[0] ? mcand : '0;

  RippleCarry u_add (
    .a    (acc[PROD_W-1:ADD_W]),
    .b    (addend),
    .cin  (1'b0),
    .cout (carry),
    .s    (sum)
  );

  // Carry-out becomes the new MSB, so the 17-bit sum survives the right shift.
  assign acc_step  = {carry, sum, acc[ADD_W-1:1]};
  assign step_last = (cnt == CNT_W'(STEPS - 1));

  // State and status flags.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_next;
      busy  <= busy_next;
      done  <= done_next;
    end
  end

  // Next-state and next-flag decode; flags depend on state and start only.
  always_comb begin
    state_next = state;
    busy_next  = 1'b0;
    done_next  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          state_next = ST_RUN;
          busy_next  = 1'b1;
        end
      end
      ST_RUN: begin
        busy_next = 1'b1;
        if (step_last) begin
          state_next = ST_DONE;
          done_next  = 1'b1;
        end
      end
      ST_DONE: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // Operand capture, shift-and-add datapath and product register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mcand <= '0;
      acc   <= '0;
      cnt   <= '0;
      p     <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            mcand <= ADD_W'(a);
            acc   <= {{ADD_W{1'b0}}, ADD_W'(b)};
            cnt   <= '0;
          end
        end
        ST_RUN: begin
          acc <= acc_step;
          cnt <= CNT_W'(cnt + CNT_W'(1));
          if (step_last) begin
            p <= (2*WIDTH)'(acc_step);
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_shift_add_mult8.sv
// Directed bench for shift_add_mult8: latency, busy window, products, back-to-back,
// held start with operand changes, and reset abort.
module tb_shift_add_mult8;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [7:0]  a;
  logic [7:0]  b;
  logic        busy;
  logic        done;
  logic [15:0] p;

  int total = 0;
  int bad   = 0;

  shift_add_mult8 #(.WIDTH(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .p     (p)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, got, exp);
    end
  endtask

  // Launch at the current negedge, keep start high for 'keep' cycles, optionally
  // scramble the operand inputs mid-run, then wait for done.
  task automatic run_op(input string tag, input logic [7:0] av, input logic [7:0] bv,
                        input int keep, input bit scramble, input int exp_lat,
                        input logic [15:0] exp_p);
    int n;
    int bc;
    bit seen;
    a = av;
    b = bv;
    start = 1'b1;
    n = 0;
    bc = 0;
    seen = 1'b0;
    while (!seen && n < 30) begin
      @(posedge clk);
      @(negedge clk);
      n++;
      if (n >= keep) start = 1'b0;
      if (scramble && n == 3) begin
        a = ~av;
        b = ~bv;
      end
      if (busy) bc++;
      if (done) seen = 1'b1;
    end
    check({tag, " done_seen"}, 16'(seen), 16'd1);
    check({tag, " latency"}, 16'(n), 16'(exp_lat));
    check({tag, " busy_cycles"}, 16'(bc), 16'd9);
    check({tag, " product"}, p, exp_p);
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    a = 8'h00;
    b = 8'h00;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    check("reset busy", 16'(busy), 16'd0);
    check("reset done", 16'(done), 16'd0);
    check("reset p", p, 16'h0000);

    // 5*3 and the single-cycle done pulse.
    run_op("5x3", 8'd5, 8'd3, 1, 1'b0, 9, 16'd15);
    @(posedge clk);
    @(negedge clk);
    check("5x3 done_drop", 16'(done), 16'd0);
    check("5x3 busy_drop", 16'(busy), 16'd0);
    check("5x3 p_hold", p, 16'd15);

    // Carry-out shifted in on every step.
    run_op("ffxff", 8'hFF, 8'hFF, 1, 1'b0, 9, 16'hFE01);
    @(posedge clk);
    @(negedge clk);

    // Back-to-back: start held from the done cycle is ignored in DONE, accepted next edge.
    run_op("00xab", 8'h00, 8'hAB, 1, 1'b0, 9, 16'h0000);
    run_op("80x02", 8'h80, 8'h02, 2, 1'b0, 10, 16'h0100);
    @(posedge clk);
    @(negedge clk);

    // Start held continuously, operand inputs disturbed during RUN.
    run_op("hold 12x34", 8'h12, 8'h34, 99, 1'b1, 9, 16'h03A8);
    run_op("hold 0fx11", 8'h0F, 8'h11, 99, 1'b1, 10, 16'h00FF);
    run_op("hold 21x03", 8'h21, 8'h03, 2, 1'b0, 10, 16'h0063);
    @(posedge clk);
    @(negedge clk);

    // Reset asserted on the 4th RUN edge of 7*9.
    a = 8'd7;
    b = 8'd9;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("abort busy", 16'(busy), 16'd0);
    check("abort done", 16'(done), 16'd0);
    check("abort p", p, 16'h0000);
    rst_n = 1'b1;
    begin
      int dcnt;
      dcnt = 0;
      for (int i = 0; i < 12; i++) begin
        @(posedge clk);
        @(negedge clk);
        if (done) dcnt++;
      end
      check("abort no_done", 16'(dcnt), 16'd0);
    end
    run_op("7x9 after abort", 8'd7, 8'd9, 1, 1'b0, 9, 16'd63);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
